// File: rtl/seven_seg_display_arbiter_if.sv
// Requester/display bundle for seven_seg_display_arbiter.
// The master side drives requests and patterns; the slave side is the arbiter.
interface seven_seg_display_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    urgent;
    logic [14*NUM_REQ-1:0] pattern_in;
    logic [NUM_REQ-1:0]    ack;
    logic [6:0]            display_1;
    logic [6:0]            display_2;
    logic [ID_W-1:0]       grant_id;
    logic                  busy;

    modport master (
        output req, urgent, pattern_in,
        input  ack, display_1, display_2, grant_id, busy
    );

    modport slave (
        input  req, urgent, pattern_in,
        output ack, display_1, display_2, grant_id, busy
    );
endinterface

// File: rtl/seven_seg_display_arbiter.sv
// Time-shares a two-digit seven-segment display among NUM_REQ requesters (IDLE/SHOW/GAP).
// Optional macro SEVSEG_PREEMPT_EN: urgent requests may preempt a non-urgent grant in SHOW.
module seven_seg_display_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ID_W        = 2,
    parameter int unsigned HOLD_CYCLES = 100000000,
    parameter int unsigned GAP_CYCLES  = 5000000,
    parameter int unsigned CNT_W       = 27
) (
    input logic                        clock,
    input logic                        reset,
    seven_seg_display_arbiter_if.slave bus
);
    localparam logic [6:0] Blank = 7'h7F;

    typedef enum logic [1:0] {StIdle, StShow, StGap} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    gid_q, gid_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [6:0]         disp1_q, disp1_d;
    logic [6:0]         disp2_q, disp2_d;

    logic [NUM_REQ-1:0] req_urg;
    logic               urg_hit;
    logic [ID_W-1:0]    urg_id;
    logic [ID_W-1:0]    rr_id;
    logic [ID_W-1:0]    rr_idx;
    logic               do_grant;
    logic [ID_W-1:0]    g_id;
    logic               g_urg;
    logic [13:0]        g_pat;

    function automatic logic [13:0] pick_pat(input logic [14*NUM_REQ-1:0] pats,
                                             input logic [ID_W-1:0]       id);
        logic [13:0] p;
        p = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (ID_W'(k) == id) p = pats[14*k +: 14];
        end
        return p;
    endfunction

    assign req_urg = bus.req & bus.urgent;

    // Urgent: lowest index wins. Otherwise scan downward so the nearest after ptr is kept.
    always_comb begin
        urg_hit = 1'b0;
        urg_id  = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_urg[i]) begin
                urg_hit = 1'b1;
                urg_id  = ID_W'(i);
            end
        end
        rr_id  = '0;
        rr_idx = '0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            rr_idx = ID_W'((32'(ptr_q) + 32'(k)) % NUM_REQ);
            if (bus.req[rr_idx]) rr_id = rr_idx;
        end
    end

`ifdef SEVSEG_PREEMPT_EN
    logic               urg_q, urg_d;
    logic [NUM_REQ-1:0] pre_mask;
    logic               pre_hit;
    logic [ID_W-1:0]    pre_id;

    assign pre_mask = req_urg & ~(NUM_REQ'(1) << gid_q);

    always_comb begin
        pre_hit = 1'b0;
        pre_id  = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (pre_mask[i]) begin
                pre_hit = 1'b1;
                pre_id  = ID_W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        gid_d    = gid_q;
        ack_d    = '0;
        disp1_d  = disp1_q;
        disp2_d  = disp2_q;
        do_grant = 1'b0;
        g_id     = '0;
        g_urg    = 1'b0;
        g_pat    = '0;
`ifdef SEVSEG_PREEMPT_EN
        urg_d    = urg_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    do_grant = 1'b1;
                    g_urg    = urg_hit;
                    g_id     = urg_hit ? urg_id : rr_id;
                end
            end
            StShow: begin
`ifdef SEVSEG_PREEMPT_EN
                if (!urg_q && pre_hit) begin
                    do_grant = 1'b1;
                    g_urg    = 1'b1;
                    g_id     = pre_id;
                end else
`endif
                if (cnt_q == '0) begin
                    disp1_d = Blank;
                    disp2_d = Blank;
                    cnt_d   = CNT_W'(GAP_CYCLES - 1);
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == '0) state_d = StIdle;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (do_grant) begin
            g_pat   = pick_pat(bus.pattern_in, g_id);
            state_d = StShow;
            cnt_d   = CNT_W'(HOLD_CYCLES - 1);
            ack_d   = NUM_REQ'(1) << g_id;
            gid_d   = g_id;
            ptr_d   = g_id;
            disp1_d = g_pat[13:7];
            disp2_d = g_pat[6:0];
`ifdef SEVSEG_PREEMPT_EN
            urg_d   = g_urg;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            gid_q   <= '0;
            ack_q   <= '0;
            disp1_q <= Blank;
            disp2_q <= Blank;
`ifdef SEVSEG_PREEMPT_EN
            urg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            ack_q   <= ack_d;
            disp1_q <= disp1_d;
            disp2_q <= disp2_d;
`ifdef SEVSEG_PREEMPT_EN
            urg_q   <= urg_d;
`endif
        end
    end

    assign bus.ack       = ack_q;
    assign bus.display_1 = disp1_q;
    assign bus.display_2 = disp2_q;
    assign bus.grant_id  = gid_q;
    assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_seven_seg_display_arbiter.sv
// Self-checking bench: vector table, directed multi-cycle sequences, then randomized
// traffic against a time-based reference model of grants, dwell and gap.
module tb_seven_seg_display_arbiter;
    localparam int NR   = 4;
    localparam int IDW  = 2;
    localparam int HOLD = 8;
    localparam int GAP  = 2;
    localparam int CW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seven_seg_display_arbiter_if #(.NUM_REQ(NR), .ID_W(IDW)) bus ();

    seven_seg_display_arbiter #(
        .NUM_REQ(NR), .ID_W(IDW), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .CNT_W(CW)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: a grant at edge g shows for edges g..g+HOLD-1, is busy through
    // g+HOLD+GAP-1, and the next IDLE arbitration may happen at edge g+HOLD+GAP+1.
    int         t_m = 0;
    int         g_m = -1000;
    int         mptr = NR - 1;
    int         mgid = 0;
    bit         murg = 1'b0;
    logic [13:0] mpat = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [13:0] pat_of(input int k);
        return bus.pattern_in[14*k +: 14];
    endfunction

    function automatic logic [20:0] outs();
        return {bus.ack, bus.display_1, bus.display_2, bus.busy, bus.grant_id};
    endfunction

    task automatic model_edge();
        logic [NR-1:0] ru;
        int w;
        bit u;
        w = -1;
        u = 1'b0;
        if (rst) begin
            g_m = -1000; mptr = NR - 1; mgid = 0; murg = 1'b0;
        end else begin
            ru = bus.req & bus.urgent;
            if (t_m >= g_m + HOLD + GAP + 1) begin
                if (ru != 0) begin
                    for (int i = 0; i < NR; i++) if (ru[i] && w < 0) w = i;
                    u = 1'b1;
                end else begin
                    for (int s = 1; s <= NR; s++)
                        if (bus.req[(mptr + s) % NR] && w < 0) w = (mptr + s) % NR;
                end
            end
`ifdef SEVSEG_PREEMPT_EN
            else if (!murg && t_m >= g_m + 1 && t_m <= g_m + HOLD) begin
                for (int i = 0; i < NR; i++) if (ru[i] && i != mgid && w < 0) w = i;
                u = 1'b1;
            end
`endif
            if (w >= 0) begin
                g_m = t_m; mgid = w; mptr = w; murg = u; mpat = pat_of(w);
            end
        end
        t_m++;
    endtask

    task automatic model_check();
        int d;
        logic [NR-1:0] ea;
        logic [6:0] e1, e2;
        logic eb;
        d  = t_m - 1 - g_m;
        ea = (d == 0) ? (NR'(1) << mgid) : '0;
        e1 = (d < HOLD) ? mpat[13:7] : 7'h7F;
        e2 = (d < HOLD) ? mpat[6:0] : 7'h7F;
        eb = (d <= HOLD + GAP - 1);
        check("random_vs_model", 32'(outs()), 32'({ea, e1, e2, eb, IDW'(mgid)}));
    endtask

    task automatic tick(input bit cmp);
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        if (cmp) model_check();
    endtask

    task automatic wait_ack(input int budget, output int id, output int when);
        id = -1;
        when = -1;
        for (int n = 0; n < budget && id < 0; n++) begin
            tick(1'b0);
            if (bus.ack != 0) begin
                for (int i = 0; i < NR; i++) if (bus.ack[i]) id = i;
                when = cyc;
                check("ack_onehot", 32'($onehot(bus.ack)), 32'd1);
            end
        end
        if (id < 0) check("ack_timeout", 32'(id), 32'hFFFF_FFFF - 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            tick(1'b0);
            n++;
        end
        check("busy_falls", 32'(bus.busy), 32'd0);
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [20:0] exp;
    } vec_t;

    vec_t tbl[16];

    function automatic logic [20:0] mk(input logic [3:0] a, input logic [13:0] p,
                                       input logic b, input logic [1:0] g);
        return {a, p[13:7], p[6:0], b, g};
    endfunction

    localparam logic [13:0] P0 = {7'h40, 7'h79};
    localparam logic [13:0] P1 = {7'h79, 7'h24};
    localparam logic [13:0] P2 = {7'h30, 7'h19};
    localparam logic [13:0] P3 = {7'h12, 7'h02};
    localparam logic [13:0] BL = {7'h7F, 7'h7F};

    int id, when, t0, prev, cnt;
    int order[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 3; i++) tbl[i] = '{1'b1, 4'b0000, mk(4'b0, BL, 1'b0, 2'd0)};
        tbl[3] = '{1'b0, 4'b0000, mk(4'b0, BL, 1'b0, 2'd0)};
        tbl[4] = '{1'b0, 4'b0001, mk(4'b0001, P0, 1'b1, 2'd0)};
        for (int i = 5; i < 12; i++) tbl[i] = '{1'b0, 4'b0000, mk(4'b0, P0, 1'b1, 2'd0)};
        for (int i = 12; i < 14; i++) tbl[i] = '{1'b0, 4'b0000, mk(4'b0, BL, 1'b1, 2'd0)};
        for (int i = 14; i < 16; i++) tbl[i] = '{1'b0, 4'b0000, mk(4'b0, BL, 1'b0, 2'd0)};

        bus.req = '0;
        bus.urgent = '0;
        bus.pattern_in = {P3, P2, P1, P0};

        // Reset, single short request, dwell and gap.
        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].rst;
            bus.req = tbl[i].req;
            tick(1'b0);
            check($sformatf("table_row%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // Continuous requests from reset: round-robin 0,1,2,3,0 with 11-cycle spacing.
        rst = 1'b1; tick(1'b0); rst = 1'b0;
        bus.req = 4'b1111;
        prev = -1;
        for (int k = 0; k < 5; k++) begin
            wait_ack(20, id, when);
            check($sformatf("rr_order%0d", k), 32'(id), 32'(order[k]));
            if (prev >= 0) check($sformatf("rr_spacing%0d", k), 32'(when - prev), 32'd11);
            prev = when;
        end
        bus.req = '0;
        wait_idle();

        // Urgent beats round-robin; the non-urgent one follows.
        bus.req = 4'b0110; bus.urgent = 4'b0100;
        wait_ack(20, id, when);
        check("urgent_first", 32'(id), 32'd2);
        bus.req = 4'b0010; bus.urgent = '0;
        wait_ack(20, id, when);
        check("urgent_then_rr", 32'(id), 32'd1);
        check("urgent_then_rr_gid", 32'(bus.grant_id), 32'd1);
        bus.req = '0;
        wait_idle();

        // Reset in the middle of SHOW, then requester 3 from the reset pointer.
        bus.req = 4'b0001;
        wait_ack(20, id, when);
        bus.req = '0;
        for (int i = 0; i < 3; i++) tick(1'b0);
        rst = 1'b1; tick(1'b0);
        check("mid_show_reset", 32'(outs()), 32'(mk(4'b0, BL, 1'b0, 2'd0)));
        rst = 1'b0; bus.req = 4'b1000;
        tick(1'b0);
        check("after_reset_req3", 32'(outs()), 32'(mk(4'b1000, P3, 1'b1, 2'd3)));
        bus.req = '0;

        // Urgent request arriving while a non-urgent grant is on display.
        rst = 1'b1; tick(1'b0); rst = 1'b0;
        bus.req = 4'b0001;
        tick(1'b0);
        t0 = cyc;
        check("preempt_base_ack", 32'(bus.ack), 32'b0001);
        bus.req = '0;
        tick(1'b0); tick(1'b0);
        bus.req = 4'b0100; bus.urgent = 4'b0100;
`ifdef SEVSEG_PREEMPT_EN
        tick(1'b0);
        check("preempt_ack", 32'(outs()), 32'(mk(4'b0100, P2, 1'b1, 2'd2)));
        bus.req = '0; bus.urgent = '0;
        cnt = 1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0);
            if ({bus.display_1, bus.display_2} == P2) cnt++;
        end
        check("preempt_dwell", 32'(cnt), 32'(HOLD));
`else
        wait_ack(20, id, when);
        check("no_preempt_id", 32'(id), 32'd2);
        check("no_preempt_delay", 32'(when - t0), 32'(HOLD + GAP + 1));
        bus.req = '0; bus.urgent = '0;
`endif
        wait_idle();

        // Randomized traffic compared every cycle with the reference model.
        rst = 1'b1; tick(1'b0); rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            tick(1'b1);
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
            bus.urgent = 4'($urandom) & 4'($urandom) & 4'($urandom);
            bus.pattern_in = {24'($urandom), 32'($urandom)};
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seven_seg_display_arbiter.md
Name: seven_seg_display_arbiter

Overview:
Shares the two-digit seven-segment display between up to NUM_REQ requesters, such as PC status, key echo and error codes. Each requester offers a 14-bit segment pattern (two digits × 7 cathodes) with a req/ack handshake. The arbiter grants one requester at a time and latches its pattern. It holds the pattern on display_1/display_2 for a fixed dwell, then inserts a blank gap. Its outputs feed the existing display multiplexing controller directly.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of grant_id; must be ≥ clog2(NUM_REQ)
HOLD_CYCLES, 100000000, dwell per grant in clock cycles (≥1; 1 s at 100 MHz)
GAP_CYCLES, 5000000, blank interval after each dwell (≥1)
CNT_W, 27, dwell/gap counter width; must hold max(HOLD_CYCLES, GAP_CYCLES)

Ports:
clock  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester request level
urgent  input  NUM_REQ  per-requester priority qualifier; only meaningful with req
pattern_in  input  14*NUM_REQ  requester k pattern at [14k+13:14k]; [14k+13:14k+7] = digit 1, [14k+6:14k] = digit 2
ack  output  NUM_REQ  one-cycle pulse; pattern of the granted requester captured
display_1  output  7  cathode pattern, digit 1 (active-low segments)
display_2  output  7  cathode pattern, digit 2
grant_id  output  ID_W  index of current/last granted requester
busy  output  1  high in SHOW or GAP

Behaviour:
- Clocking/reset: one clock domain (clock); reset is synchronous, active-high, sampled on the rising edge.
- Reset values: display_1 = display_2 = 7'h7F (blank); ack = 0; grant_id = 0; busy = 0; state = IDLE; counter = 0; round-robin pointer = NUM_REQ-1, so requester 0 wins first.
- States: IDLE, SHOW, GAP.
- IDLE, no req: displays stay blank.
- IDLE, any req bit high at an edge:
  - Choose the winner: if any req&urgent bit is set, take the lowest-index one among those; otherwise round-robin, searching upward from pointer+1 with wrap.
  - On that same edge: latch the winner's pattern into display_1/display_2; set ack[winner] = 1 for exactly one cycle; set grant_id = winner; set pointer = winner; load counter = HOLD_CYCLES-1; go to SHOW.
  - Latency from req sampled to display/ack update is 1 edge.
- SHOW: counter decrements each cycle. While counter == 0, the next edge blanks the displays, loads counter = GAP_CYCLES-1 and enters GAP. The pattern is therefore visible for exactly HOLD_CYCLES cycles.
- GAP: displays blank. Counter decrements; while counter == 0, the next edge goes to IDLE. Arbitration in IDLE happens on the following edge, so there are GAP_CYCLES+1 blank cycles between grants when requests are continuous.
- Requests are level-based. Requests are ignored outside IDLE; ack never pulses in SHOW or GAP (except preemption, see Optional Feature).
- Changes to pattern_in or req of the granted requester after capture have no effect on the displayed pattern.
- A requester holding req high across grants is re-served only after all other active requesters, because of round-robin fairness.
- Only one ack bit is high in any cycle; ack is all-zero except on grant edges.
- Reset asserted in any state returns everything to reset values on that edge; no ack is emitted.
- Counter arithmetic is unsigned CNT_W bits; it never decrements below 0.

Optional Feature:
SEVSEG_PREEMPT_EN
- Defined: in SHOW, if the current grant was non-urgent and another requester has req&urgent high, the next edge grants that urgent requester immediately. Grant follows the IDLE rules: ack pulse, new pattern, counter = HOLD_CYCLES-1, and the state stays SHOW with no gap. An urgent grant is never preempted. The arbiter needs one stored bit recording whether the current grant is urgent.
- Undefined: urgent affects IDLE arbitration only; SHOW always runs its full dwell.

Test Plan (HOLD_CYCLES=8, GAP_CYCLES=2, NUM_REQ=4):
1. Reset held 3 cycles, then released, with all req=0 → display_1/2 = 7'h7F, ack = 0, busy = 0 indefinitely.
2. req=4'b0001, pattern0 = {7'h40, 7'h79}, held 1 cycle → one cycle later ack = 4'b0001 for 1 cycle, display = 7'h40/7'h79 for exactly 8 cycles, blank for 2, busy falls, grant_id = 0.
3. req=4'b1111 held continuously → grants in order 0, 1, 2, 3, 0; 11 cycles between successive ack pulses.
4. req=4'b0110, urgent=4'b0100 in IDLE with pointer = 0 → requester 2 granted before 1; requester 1 granted next.
5. Reset asserted in cycle 4 of SHOW → next edge displays blank, busy = 0, no ack; after release with req=4'b1000, requester 3 is granted (pointer reset does not block).
6. SEVSEG_PREEMPT_EN defined: requester 0 non-urgent in SHOW cycle 3, requester 2 raises req+urgent → next edge ack = 4'b0100 and requester 2's pattern is shown for 8 cycles. Without the macro, requester 2 is granted only after requester 0's 8 SHOW cycles, 2 GAP cycles and 1 IDLE edge.
